// File: rtl/panda_pkg.sv
// Shared types and helpers for the panda memory arbiter.
package panda_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,  // nothing outstanding, arbitrating combinationally
    ARB_REQ  = 2'd1,  // request presented, waiting for mem_gnt_i
    ARB_RESP = 2'd2   // request accepted, waiting for mem_rvalid_i
  } arb_state_e;

  // Which requester owns the shared memory port.
  typedef enum logic {
    ARB_OWNER_INSTR = 1'b0,
    ARB_OWNER_DATA  = 1'b1
  } arb_owner_e;

  // Width of the instruction-starvation counter (limit range 1..15).
  localparam int unsigned STARVE_CNT_W = 4;

  // Saturating increment of the starvation counter.
  function automatic logic [STARVE_CNT_W-1:0] starve_inc(
    input logic [STARVE_CNT_W-1:0] cnt,
    input logic [STARVE_CNT_W-1:0] limit
  );
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/panda_mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one shared memory
// port. One transaction outstanding at a time; data has priority, but
// instruction fetch wins once it has waited through StarveLimit data grants.
module panda_mem_arbiter
  import panda_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] LimitC = STARVE_CNT_W'(StarveLimit);

  arb_state_e              r_state;
  arb_owner_e              r_owner;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  logic       w_any_req;
  arb_owner_e w_pick;
  arb_owner_e w_owner;
  logic       w_mem_req;
  logic       w_grant;
  logic       w_resp;

  // Winner selection and request presentation; zero-cycle latency from IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_any_req = instr_req_i | data_req_i;
    w_pick    = ARB_OWNER_DATA;
    if (instr_req_i && (!data_req_i || (r_starve_cnt == LimitC))) begin
      w_pick = ARB_OWNER_INSTR;
    end
    // Once a request is presented the latched owner is held until granted.
    w_owner   = (r_state == ARB_IDLE) ? w_pick : r_owner;
    w_mem_req = !rst_i && (((r_state == ARB_IDLE) && w_any_req) ||
                           (r_state == ARB_REQ));
    w_grant   = w_mem_req && mem_gnt_i;
    w_resp    = !rst_i && (r_state == ARB_RESP) && mem_rvalid_i;
  end

  // Memory-side payload mux; payload is forced to zero when not requesting.
  always_comb begin
    mem_req_o   = w_mem_req;
    mem_addr_o  = '0;
    mem_we_o    = '0;
    mem_wdata_o = '0;
    if (w_mem_req) begin
      if (w_owner == ARB_OWNER_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  // Requester-side grant and response routing to the owner only.
  always_comb begin
    instr_gnt_o    = w_grant && (w_owner == ARB_OWNER_INSTR);
    data_gnt_o     = w_grant && (w_owner == ARB_OWNER_DATA);
    instr_rvalid_o = w_resp && (r_owner == ARB_OWNER_INSTR);
    data_rvalid_o  = w_resp && (r_owner == ARB_OWNER_DATA);
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
  end

  // Arbiter FSM, owner latch and instruction-starvation counter.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state      <= ARB_IDLE;
      r_owner      <= ARB_OWNER_INSTR;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant) begin
        if (w_owner == ARB_OWNER_INSTR) begin
          r_starve_cnt <= '0;
        end else if (instr_req_i) begin
          r_starve_cnt <= starve_inc(r_starve_cnt, LimitC);
        end
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick;
            r_state <= mem_gnt_i ? ARB_RESP : ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_gnt_i) r_state <= ARB_RESP;
        end
        ARB_RESP: begin
          // The response cycle never issues a new request; arbitration
          // resumes from IDLE on the following cycle.
          if (mem_rvalid_i) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // A memory response with no transaction outstanding is ignored, but flagged.
  a_rvalid_only_in_resp: assert property (
    @(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> (r_state == ARB_RESP)
  );

endmodule

// File: doc/panda_mem_arbiter.md
PANDA_MEM_ARBITER -- requirements
Module: panda_mem_arbiter

Interface
REQ-001 Parameter StarveLimit, default 4, legal range 1..15: consecutive data grants tolerated while instr is waiting.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 instr_req_i  in  1  instruction-fetch read request.
REQ-005 instr_addr_i  in  32  fetch address.
REQ-006 instr_gnt_o  out  1  fetch request accepted.
REQ-007 instr_rvalid_o  out  1  fetch response valid.
REQ-008 instr_rdata_o  out  32  fetch response data.
REQ-009 data_req_i  in  1  load/store request.
REQ-010 data_addr_i  in  32  load/store address.
REQ-011 data_we_i  in  4  byte write enables; 0 means read.
REQ-012 data_wdata_i  in  32  store data.
REQ-013 data_gnt_o  out  1  load/store request accepted.
REQ-014 data_rvalid_o  out  1  load/store response valid; also pulsed for stores.
REQ-015 data_rdata_o  out  32  load response data.
REQ-016 mem_req_o  out  1  shared memory request.
REQ-017 mem_addr_o  out  32  shared memory address.
REQ-018 mem_we_o  out  4  shared memory byte enables; 0 for fetches.
REQ-019 mem_wdata_o  out  32  shared memory write data.
REQ-020 mem_gnt_i  in  1  memory accepted request this cycle.
REQ-021 mem_rvalid_i  in  1  memory response valid.
REQ-022 mem_rdata_i  in  32  memory response data.

Function
REQ-023 FSM states: ARB_IDLE, ARB_REQ (request presented, awaiting mem_gnt_i) and ARB_RESP (granted, awaiting mem_rvalid_i); at most one outstanding transaction.
REQ-024 ARB_IDLE: with any request pending, pick winner combinationally and drive mem_req_o=1 with the winner's addr/we/wdata in the same cycle (zero-cycle latency).
REQ-025 Winner: data over instr, except instr wins when instr_req_i=1 and starve_cnt==StarveLimit.
REQ-026 Transitions: ARB_IDLE + mem_gnt_i -> ARB_RESP; ARB_IDLE + request without mem_gnt_i -> ARB_REQ with owner latched; ARB_REQ + mem_gnt_i -> ARB_RESP; ARB_RESP + mem_rvalid_i -> ARB_IDLE.
REQ-027 In ARB_REQ the latched owner is held; a newly raised higher-priority request does not displace it before mem_gnt_i.
REQ-028 Owner's gnt output equals mem_gnt_i while its request is presented; the other gnt output stays 0.
REQ-029 In ARB_RESP, mem_req_o=0; mem_rvalid_i and mem_rdata_i route to the owner's rvalid/rdata only; non-owner rvalid stays 0.
REQ-030 No new request is issued in the cycle mem_rvalid_i returns; the next arbitration occurs in ARB_IDLE one cycle later.
REQ-031 starve_cnt saturates at StarveLimit; it increments on each data grant issued while instr_req_i=1 and clears on each instr grant.
REQ-032 mem_rvalid_i outside ARB_RESP is ignored; a simulation assertion flags it.
REQ-033 Requesters hold req/addr/we/wdata stable until gnt; the arbiter does not register payload.
REQ-034 While mem_req_o=0, mem_addr_o, mem_we_o and mem_wdata_o are driven to 0.

Reset
REQ-035 When rst_i is high at a clock edge: state becomes ARB_IDLE, starve_cnt becomes 0 and the owner becomes instr; mem_req_o, both gnt outputs and both rvalid outputs read 0 while rst_i is high.
REQ-036 Reset mid-transaction abandons the in-flight response; the memory is reset by the same rst_i.

Structure
REQ-037 The arb_state_e (ARB_IDLE/ARB_REQ/ARB_RESP) and arb_owner_e (ARB_OWNER_INSTR/ARB_OWNER_DATA) typedefs belong in panda_pkg.
REQ-038 The block is a single module with no sub-modules; starve_cnt is 4 bits wide.

Verification
REQ-039 Both requests at 0x100 (instr) and 0x200 (data, we=0) with mem_gnt_i=1 -> mem_addr_o=0x200 and data_gnt_o=1 in the same cycle; rdata 0xDEADBEEF appears only on data_rdata_o with data_rvalid_o.
REQ-040 Data store we=4'b0011, wdata 0x1234ABCD, mem_gnt_i low for 3 cycles -> mem_req_o held with identical payload; a raised instr_req_i does not switch the owner.
REQ-041 StarveLimit=2, data and instr continuously requesting -> grant sequence data, data, instr, data, data, instr.
REQ-042 mem_rvalid_i injected while in ARB_IDLE -> no rvalid output asserted and the assertion fires.
REQ-043 rst_i asserted in ARB_RESP -> next cycle state ARB_IDLE with all gnt/rvalid outputs 0; the later stale mem_rvalid_i is ignored.
